// File: rtl/cam_buffer_pkg.sv
// cam_buffer_pkg
// Shared definitions for the camera frame buffer controller: the sizes of the
// frame buffer RAM and the controller state encoding.
package cam_buffer_pkg;

    // Frame buffer geometry. Pointers must be able to hold DEPTH itself
    // (one past the last address), so DEPTH has to stay below 2**ADDR.
    localparam int CAM_BUF_DEPTH = 16000;
    localparam int CAM_BUF_ADDR  = 16;
    localparam int CAM_BUF_DATA  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2,
        READY    = 2'd3
    } cam_state_t;

endpackage

// File: rtl/cam_buffer_ctrl.sv
// cam_buffer_ctrl
// Sequences the shared camera frame buffer RAM: captures one packed frame
// from the capture pipeline with sequential writes, then serves pipelined
// word-by-word readout to the host side. Capture and readout use the RAM in
// disjoint states, so this block owns every RAM port.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   capture_start       pulse: arm capture of the next frame
//   frame_start         camera start-of-frame pulse
//   frame_end           camera end-of-frame pulse
//   pixel_valid         pixel_data carries one packed word (no backpressure)
//   pixel_data          packed pixel word
//   rd_start            pulse: rewind the read pointer to 0
//   rd_req              request the next word (may be held every cycle)
//   rd_valid, rd_data   read response, one cycle after an accepted rd_req
//   busy                waiting for start-of-frame or capturing
//   frame_ready         a completed frame is available for readout
//   overflow            sticky: a pixel was dropped because the buffer was full
//   frame_words         word count of the last completed frame
//   ram_wr_*            RAM write port (combinational, same cycle as the pixel)
//   ram_rd_addr/en      RAM read port (combinational, same cycle as rd_req)
//   ram_rd_data         RAM read data, valid one cycle after ram_rd_en
module cam_buffer_ctrl
    import cam_buffer_pkg::*;
#(
    parameter int ADDR  = CAM_BUF_ADDR,
    parameter int DATA  = CAM_BUF_DATA,
    parameter int DEPTH = CAM_BUF_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            capture_start,
    input  logic            frame_start,
    input  logic            frame_end,
    input  logic            pixel_valid,
    input  logic [DATA-1:0] pixel_data,
    input  logic            rd_start,
    input  logic            rd_req,
    output logic            rd_valid,
    output logic [DATA-1:0] rd_data,
    output logic            busy,
    output logic            frame_ready,
    output logic            overflow,
    output logic [ADDR-1:0] frame_words,
    output logic [ADDR-1:0] ram_wr_addr,
    output logic [DATA-1:0] ram_wr_data,
    output logic            ram_wr_en,
    output logic [ADDR-1:0] ram_rd_addr,
    output logic            ram_rd_en,
    input  logic [DATA-1:0] ram_rd_data
);

    localparam logic [ADDR-1:0] DEPTH_A = ADDR'(DEPTH);
    localparam logic [ADDR-1:0] ONE_A   = ADDR'(1);

    cam_state_t      state;
    cam_state_t      state_next;
    logic [ADDR-1:0] wr_ptr;
    logic [ADDR-1:0] rd_ptr;
    logic            rd_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the combinational RAM port drive. A pixel that arrives
    // together with frame_start is the first word of the frame, so it goes to
    // address 0 even though wr_ptr has not been cleared yet. Both enables are
    // forced low while reset is asserted so an aborted cycle never touches RAM.
    always_comb begin
        state_next  = state;
        ram_wr_en   = 1'b0;
        ram_wr_addr = wr_ptr;
        ram_wr_data = pixel_data;
        ram_rd_en   = 1'b0;
        ram_rd_addr = rd_ptr;
        case (state)
            IDLE: begin
                if (capture_start) state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (frame_start) begin
                    state_next  = CAPTURE;
                    ram_wr_en   = pixel_valid;
                    ram_wr_addr = '0;
                end
            end
            CAPTURE: begin
                ram_wr_en = pixel_valid && (wr_ptr < DEPTH_A);
                if (frame_end) state_next = READY;
            end
            READY: begin
                if (capture_start) state_next = WAIT_SOF;
                ram_rd_en = rd_req && !rd_start && (rd_ptr < frame_words);
            end
            default: state_next = IDLE;
        endcase
        if (!rst_n) begin
            ram_wr_en = 1'b0;
            ram_rd_en = 1'b0;
        end
    end

    // Pointers, frame bookkeeping and the read response. rd_hit remembers
    // whether last cycle's accepted request actually read the RAM; requests
    // past the end of the frame still answer, but with zero data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_words <= '0;
            overflow    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_hit      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
            case (state)
                WAIT_SOF: begin
                    if (frame_start) begin
                        wr_ptr   <= pixel_valid ? ONE_A : '0;
                        overflow <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (ram_wr_en) wr_ptr <= wr_ptr + ONE_A;
                    if (pixel_valid && !ram_wr_en) overflow <= 1'b1;
                    if (frame_end) begin
                        frame_words <= ram_wr_en ? (wr_ptr + ONE_A) : wr_ptr;
                        rd_ptr      <= '0;
                    end
                end
                READY: begin
                    if (rd_start) begin
                        rd_ptr <= '0;
                    end else if (rd_req) begin
                        rd_valid <= 1'b1;
                        rd_hit   <= ram_rd_en;
                        if (ram_rd_en) rd_ptr <= rd_ptr + ONE_A;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_data     = rd_hit ? ram_rd_data : '0;
    assign busy        = (state == WAIT_SOF) || (state == CAPTURE);
    assign frame_ready = (state == READY);

endmodule

// File: tb/tb_cam_buffer_ctrl.sv
// tb_cam_buffer_ctrl
// Directed bench for cam_buffer_ctrl. Stimulus pushes expected RAM writes and
// read responses into queues; independent monitors pop and compare whenever
// the controller writes the RAM or raises rd_valid. A behavioural RAM with a
// one-cycle registered read port sits on the ram_* ports.
module tb_cam_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        capture_start = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [31:0] pixel_data = '0;
    logic        rd_start = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        busy;
    logic        frame_ready;
    logic        overflow;
    logic [15:0] frame_words;
    logic [15:0] ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic        ram_wr_en;
    logic [15:0] ram_rd_addr;
    logic        ram_rd_en;
    logic [31:0] ram_rd_data = '0;

    int tests_run = 0;
    int tests_failed = 0;
    int rd_en_count = 0;
    logic [15:0] last_wr_addr = '0;

    logic [47:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] mem [0:15999];

    cam_buffer_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .capture_start (capture_start),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .pixel_valid   (pixel_valid),
        .pixel_data    (pixel_data),
        .rd_start      (rd_start),
        .rd_req        (rd_req),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .busy          (busy),
        .frame_ready   (frame_ready),
        .overflow      (overflow),
        .frame_words   (frame_words),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data),
        .ram_wr_en     (ram_wr_en),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_en     (ram_rd_en),
        .ram_rd_data   (ram_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural frame buffer RAM with registered read data.
    always @(posedge clk) begin
        if (ram_wr_en && ram_wr_addr < 16'd16000) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en && ram_rd_addr < 16'd16000) ram_rd_data <= mem[ram_rd_addr];
    end

    // Write monitor: every RAM write must match the next expected write.
    always @(negedge clk) begin
        if (ram_wr_en) begin
            tests_run++;
            last_wr_addr = ram_wr_addr;
            if (exp_wr.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_write addr=%0d data=%h required none", ram_wr_addr, ram_wr_data);
            end else begin
                logic [47:0] e;
                e = exp_wr.pop_front();
                if ({ram_wr_addr, ram_wr_data} !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL ram_write actual addr=%0d data=%h required addr=%0d data=%h",
                             ram_wr_addr, ram_wr_data, e[47:32], e[31:0]);
                end
            end
        end
    end

    // Read monitor: every rd_valid must match the next expected word.
    always @(negedge clk) begin
        if (ram_rd_en) rd_en_count++;
        if (rd_valid) begin
            tests_run++;
            if (exp_rd.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_rd_valid data=%h required none", rd_data);
            end else begin
                logic [31:0] e;
                e = exp_rd.pop_front();
                if (rd_data !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL rd_data actual %h required %h", rd_data, e);
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the edge.
    task automatic apply_stimulus(input logic cs, input logic fs, input logic fe, input logic pv,
                                  input logic [31:0] pd, input logic rs, input logic rr);
        capture_start = cs;
        frame_start   = fs;
        frame_end     = fe;
        pixel_valid   = pv;
        pixel_data    = pd;
        rd_start      = rs;
        rd_req        = rr;
        @(posedge clk);
        #1;
        capture_start = 1'b0;
        frame_start   = 1'b0;
        frame_end     = 1'b0;
        pixel_valid   = 1'b0;
        rd_start      = 1'b0;
        rd_req        = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        idle(3);
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_frame_ready", {31'b0, frame_ready}, 32'd0);
        check_output("reset_overflow", {31'b0, overflow}, 32'd0);
        check_output("reset_frame_words", {16'b0, frame_words}, 32'd0);
        check_output("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Ten-word frame
        apply_stimulus(1, 0, 0, 0, 32'h0, 0, 0);
        check_output("armed_busy", {31'b0, busy}, 32'd1);
        apply_stimulus(0, 1, 0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            exp_wr.push_back({16'(i), 32'h100 + 32'(i)});
            apply_stimulus(0, 0, 0, 1, 32'h100 + 32'(i), 0, 0);
        end
        apply_stimulus(0, 0, 1, 0, 32'h0, 0, 0);
        check_output("f1_frame_ready", {31'b0, frame_ready}, 32'd1);
        check_output("f1_busy", {31'b0, busy}, 32'd0);
        check_output("f1_frame_words", {16'b0, frame_words}, 32'd10);
        check_output("f1_overflow", {31'b0, overflow}, 32'd0);
        check_output("f1_writes_drained", exp_wr.size(), 32'd0);

        // Read 12 words: 10 stored plus two past the end returning zero
        rd_en_count = 0;
        for (int i = 0; i < 12; i++) begin
            exp_rd.push_back(i < 10 ? 32'h100 + 32'(i) : 32'h0);
            apply_stimulus(0, 0, 0, 0, 32'h0, 0, 1);
        end
        idle(2);
        check_output("f1_reads_drained", exp_rd.size(), 32'd0);
        check_output("f1_rd_en_count", rd_en_count, 32'd10);
        check_output("f1_rd_valid_low", {31'b0, rd_valid}, 32'd0);

        // Rewind, three reads, then rd_start+rd_req together drops the request
        apply_stimulus(0, 0, 0, 0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            exp_rd.push_back(32'h100 + 32'(i));
            apply_stimulus(0, 0, 0, 0, 32'h0, 0, 1);
        end
        apply_stimulus(0, 0, 0, 0, 32'h0, 1, 1);
        exp_rd.push_back(32'h100);
        apply_stimulus(0, 0, 0, 0, 32'h0, 0, 1);
        idle(2);
        check_output("rewind_reads_drained", exp_rd.size(), 32'd0);

        // Second frame: pre-SOF pixels and rd_req ignored, SOF pixel to addr 0,
        // mid-frame capture_start/frame_start ignored, EOF pixel counted
        apply_stimulus(1, 0, 0, 0, 32'h0, 0, 0);
        check_output("f2_words_held", {16'b0, frame_words}, 32'd10);
        check_output("f2_frame_ready_low", {31'b0, frame_ready}, 32'd0);
        apply_stimulus(0, 0, 0, 1, 32'hDEAD0000, 0, 1);
        apply_stimulus(0, 0, 0, 1, 32'hDEAD0001, 0, 1);
        exp_wr.push_back({16'd0, 32'h200});
        apply_stimulus(0, 1, 0, 1, 32'h200, 0, 0);
        exp_wr.push_back({16'd1, 32'h201});
        apply_stimulus(1, 0, 0, 1, 32'h201, 0, 1);
        exp_wr.push_back({16'd2, 32'h202});
        apply_stimulus(0, 1, 0, 1, 32'h202, 0, 0);
        exp_wr.push_back({16'd3, 32'h203});
        apply_stimulus(0, 0, 1, 1, 32'h203, 0, 0);
        check_output("f2_frame_words", {16'b0, frame_words}, 32'd4);
        check_output("f2_frame_ready", {31'b0, frame_ready}, 32'd1);
        check_output("f2_writes_drained", exp_wr.size(), 32'd0);
        for (int i = 0; i < 5; i++) begin
            exp_rd.push_back(i < 4 ? 32'h200 + 32'(i) : 32'h0);
            apply_stimulus(0, 0, 0, 0, 32'h0, 0, 1);
        end
        idle(2);
        check_output("f2_reads_drained", exp_rd.size(), 32'd0);

        // Overflow frame: 16002 pixels, only 16000 stored
        apply_stimulus(1, 0, 0, 0, 32'h0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 16002; i++) begin
            if (i < 16000) exp_wr.push_back({16'(i), 32'hA5A50000 ^ 32'(i)});
            apply_stimulus(0, 0, 0, 1, 32'hA5A50000 ^ 32'(i), 0, 0);
            if (i == 15999) check_output("ovf_not_yet", {31'b0, overflow}, 32'd0);
        end
        check_output("ovf_last_addr", {16'b0, last_wr_addr}, 32'd15999);
        apply_stimulus(0, 0, 1, 0, 32'h0, 0, 0);
        check_output("ovf_overflow", {31'b0, overflow}, 32'd1);
        check_output("ovf_frame_words", {16'b0, frame_words}, 32'd16000);
        check_output("ovf_writes_drained", exp_wr.size(), 32'd0);

        // Reset mid-capture after 5 pixels
        apply_stimulus(1, 0, 0, 0, 32'h0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 32'h0, 0, 0);
        check_output("sof_clears_overflow", {31'b0, overflow}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            exp_wr.push_back({16'(i), 32'h300 + 32'(i)});
            apply_stimulus(0, 0, 0, 1, 32'h300 + 32'(i), 0, 0);
        end
        rst_n = 1'b0;
        apply_stimulus(0, 0, 0, 1, 32'h3FF, 0, 1);
        rst_n = 1'b1;
        check_output("rst_busy", {31'b0, busy}, 32'd0);
        check_output("rst_frame_ready", {31'b0, frame_ready}, 32'd0);
        check_output("rst_frame_words", {16'b0, frame_words}, 32'd0);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, 1, 32'h400 + 32'(i), 0, 1);
        idle(2);
        check_output("rst_writes_drained", exp_wr.size(), 32'd0);
        check_output("rst_reads_drained", exp_rd.size(), 32'd0);
        check_output("rst_frame_ready_idle", {31'b0, frame_ready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cam_buffer_ctrl.md
Name: cam_buffer_ctrl

Overview:
- Sequences the shared 16000 x 32 camera frame buffer RAM.
- Accepts one packed camera frame from the capture pipeline and writes it sequentially.
- Then serves word-by-word pipelined readout to the host-readout side.
- Owns every RAM port; capture and readout never touch the RAM in the same state.

Parameters:
- ADDR, 16, RAM address width.
- DATA, 32, RAM data/word width.
- DEPTH, 16000, RAM words; highest legal address is DEPTH-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- capture_start  in  1  one-cycle pulse: arm capture of the next frame.
- frame_start  in  1  camera start-of-frame pulse.
- frame_end  in  1  camera end-of-frame pulse.
- pixel_valid  in  1  pixel_data holds one packed word this cycle; no backpressure.
- pixel_data  in  DATA  packed pixel word.
- rd_start  in  1  pulse: rewind read pointer to 0.
- rd_req  in  1  request next word; may be asserted every cycle.
- rd_valid  out  1  rd_data valid.
- rd_data  out  DATA  read word.
- busy  out  1  state is WAIT_SOF or CAPTURE.
- frame_ready  out  1  state is READY.
- overflow  out  1  sticky: a pixel was dropped because the buffer was full.
- frame_words  out  ADDR  number of words stored in the last completed frame.
- ram_wr_addr  out  ADDR  RAM write address.
- ram_wr_data  out  DATA  RAM write data.
- ram_wr_en  out  1  RAM write enable.
- ram_rd_addr  out  ADDR  RAM read address.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_data  in  DATA  RAM read data; registered, valid 1 cycle after ram_rd_en.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Values while rst_n=0:
  - State IDLE.
  - wr_ptr, rd_ptr, frame_words = 0.
  - overflow, rd_valid, rd_data = 0.
  - All RAM enables = 0.
  - RAM contents are not cleared.
- Reset mid-operation aborts capture or readout immediately. No RAM access occurs in the reset cycle.
- States:
  - IDLE: capture_start -> WAIT_SOF.
  - WAIT_SOF: frame_start -> CAPTURE, with wr_ptr=0 and overflow cleared. Pixels before frame_start are ignored.
  - CAPTURE:
    - Each pixel_valid with wr_ptr<DEPTH drives ram_wr_en=1, ram_wr_addr=wr_ptr, ram_wr_data=pixel_data combinationally in the same cycle; wr_ptr then increments.
    - pixel_valid with wr_ptr==DEPTH produces no write; overflow is set.
    - frame_end -> READY, with frame_words = final wr_ptr.
  - READY:
    - Readout is enabled.
    - capture_start -> WAIT_SOF. The old frame is discarded and frame_words is held until the new frame_end.
- Same-cycle cases:
  - frame_start with pixel_valid: the pixel is written to address 0.
  - frame_end with pixel_valid: the pixel is written and counted in frame_words.
  - frame_start inside CAPTURE: ignored.
  - capture_start inside WAIT_SOF or CAPTURE: ignored.
- Readout:
  - Active only in READY; rd_req in other states is ignored (no rd_valid).
  - rd_req with rd_ptr<frame_words: ram_rd_en=1 and ram_rd_addr=rd_ptr in the same cycle; rd_ptr increments. Next cycle rd_valid=1 and rd_data=ram_rd_data.
  - rd_req with rd_ptr>=frame_words: no RAM read. Next cycle rd_valid=1 and rd_data=0; rd_ptr saturates.
  - Latency is exactly 1 cycle. Back-to-back rd_req gives back-to-back rd_valid.
  - rd_valid is low in any cycle not following an accepted rd_req.
  - rd_start rewinds rd_ptr=0 and takes priority over a same-cycle rd_req, which is dropped.
  - Entering READY also sets rd_ptr=0.
- Widths: pointers are ADDR bits and must hold values up to DEPTH (requires DEPTH < 2**ADDR).

Decomposition:
- Package cam_buffer_pkg:
  - State enum: IDLE, WAIT_SOF, CAPTURE, READY.
  - CAM_BUF_DEPTH=16000, CAM_BUF_ADDR=16, CAM_BUF_DATA=32.
- No sub-module. The RAM is instantiated by the parent and connected to the ram_* ports.

Test Plan:
- Arm, frame_start, 10 pixels 0x100..0x109, frame_end -> 10 writes at addresses 0..9; frame_ready=1; frame_words=10; overflow=0.
- Read that frame with rd_req held for 12 cycles -> rd_valid for 12 cycles; data 0x100..0x109 then 0, 0; exactly 10 ram_rd_en pulses.
- Send 16002 pixels in one frame -> last write at address 15999; overflow=1; frame_words=16000.
- rd_req and rd_start in the same cycle after 3 reads -> no rd_valid the next cycle; following rd_req returns word at address 0.
- Pixels before frame_start in WAIT_SOF, and frame_end with pixel_valid in the same cycle -> pre-SOF pixels are not written; the final pixel is counted in frame_words.
- Assert rst_n=0 for one cycle mid-CAPTURE after 5 pixels -> state IDLE, frame_ready=0, frame_words=0, no further writes; rd_req ignored.
